// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduling path: FSM state encoding
// and the ceiling-log2 helper used to size index and counter fields.
package uart_pkg;

  localparam int STATEWIDTH = 3;

  typedef enum logic [STATEWIDTH-1:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Ceiling log2 with a minimum of 1 so that a field is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: requests above the pointer are preferred,
// otherwise the lowest-index request wins (mask plus priority encoder).
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;

  always_comb begin
    masked = '0;
    for (int i = 0; i < NREQ; i++) begin
      masked[i] = req[i] && (i > int'(ptr));
    end
    pick = (|masked) ? masked : req;
    // Scan downwards so the lowest set index is the one left in gnt_id.
    gnt_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) gnt_id = IDW'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte sources,
// with a forced idle gap after each frame and a watchdog on the Busy handshake.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DATAWIDTH    = 8,
  parameter int BUSY_TIMEOUT = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]           req_par_en,
  input  logic [NREQ-1:0]           req_par_typ,
  output logic [NREQ-1:0]           req_ready,
  output logic [DATAWIDTH-1:0]      P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_EN,
  output logic                      PAR_TYP,
  input  logic                      Busy,
  output logic [clog2(NREQ)-1:0]    grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int IDW     = clog2(NREQ);
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNTW    = clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(BUSY_TIMEOUT - 1);
  localparam logic [CNTW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNTW'(GAP_CYCLES - 1) : '0;
  localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t              state, state_n;
  logic [IDW-1:0]      ptr, ptr_n;
  logic [CNTW-1:0]     cnt, cnt_n;
  logic [IDW-1:0]      gid_n;
  logic [DATAWIDTH-1:0] pdata_n;
  logic                paren_n, partyp_n;
  logic                dv_n, to_n;
  logic [NREQ-1:0]     rdy_n;

  logic [IDW-1:0]      arb_id;
  logic                arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = cnt;
    gid_n    = grant_id;
    pdata_n  = P_DATA;
    paren_n  = PAR_EN;
    partyp_n = PAR_TYP;
    dv_n     = 1'b0;
    to_n     = 1'b0;
    rdy_n    = '0;
    case (state)
      IDLE: begin
        // A transmitter that is still busy (e.g. driven by another master) blocks arbitration.
        if (!Busy && arb_any) begin
          state_n       = ISSUE;
          gid_n         = arb_id;
          pdata_n       = req_data[int'(arb_id)*DATAWIDTH +: DATAWIDTH];
          paren_n       = req_par_en[arb_id];
          partyp_n      = req_par_typ[arb_id];
          dv_n          = 1'b1;
          rdy_n[arb_id] = 1'b1;
        end
      end
      ISSUE: begin
        state_n = WAIT_BUSY;
        ptr_n   = grant_id;
        cnt_n   = '0;
      end
      WAIT_BUSY: begin
        if (Busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          to_n    = 1'b1;
          cnt_n   = '0;
          state_n = AFTER_FRAME;
        end else begin
          cnt_n = cnt + CNTW'(1);
        end
      end
      WAIT_DONE: begin
        if (!Busy) begin
          cnt_n   = '0;
          state_n = AFTER_FRAME;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_n = IDLE;
        else                 cnt_n   = cnt + CNTW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= IDW'(NREQ - 1);
      cnt         <= '0;
      grant_id    <= '0;
      P_DATA      <= '0;
      PAR_EN      <= 1'b0;
      PAR_TYP     <= 1'b0;
      DATA_VALID  <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      grant_id    <= gid_n;
      P_DATA      <= pdata_n;
      PAR_EN      <= paren_n;
      PAR_TYP     <= partyp_n;
      DATA_VALID  <= dv_n;
      req_ready   <= rdy_n;
      timeout_err <= to_n;
      active      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a timestamp-based model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 4;
  localparam int GAPC = 3;
  localparam int BUSY_LEN = 6;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_par_en;
  logic [NREQ-1:0]   req_par_typ;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     P_DATA;
  logic              DATA_VALID;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              Busy;
  logic [1:0]        grant_id;
  logic              active;
  logic              timeout_err;

  uart_tx_sched #(
    .NREQ(NREQ), .DATAWIDTH(DW), .BUSY_TIMEOUT(TO), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ), .req_ready(req_ready),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Busy(Busy), .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Stub transmitter and requester agent, acting 3 ns after each rising edge.
  logic stub_en, ext_busy, auto_clr;
  int   bcnt;
  always begin
    @(posedge clk);
    #3;
    if (stub_en && DATA_VALID === 1'b1) bcnt = BUSY_LEN;
    else if (bcnt > 0) bcnt--;
    Busy = ext_busy || (bcnt > 0);
    if (auto_clr) req_valid = req_valid & ~req_ready;
  end

  // Model: frame timing kept as edge timestamps, arbitration as a modular search.
  int   cyc = 0;
  bit   m_on = 0;
  int   m_ptr, m_iss, m_free, last_fall;
  bit   m_open, m_bseen, prev_busy;
  logic       e_dv, e_to, e_act, e_pe, e_pt;
  logic [3:0] e_rdy;
  logic [1:0] e_gid;
  logic [7:0] e_pd;

  always begin
    @(posedge clk);
    cyc++;
    if (prev_busy && !Busy) last_fall = cyc;
    prev_busy = Busy;
    if (!rst) begin
      m_on = 1; m_ptr = NREQ - 1; m_open = 0; m_free = 0; m_bseen = 0;
      e_dv = 0; e_to = 0; e_act = 0; e_pe = 0; e_pt = 0; e_rdy = 0; e_gid = 0; e_pd = 0;
    end else if (m_on) begin
      e_dv = 0; e_to = 0; e_rdy = 0;
      if (m_open) begin
        if (cyc >= m_iss + 2) begin
          if (!m_bseen) begin
            if (Busy) m_bseen = 1;
            else if (cyc == m_iss + 1 + TO) begin
              e_to = 1; m_open = 0; m_free = cyc + GAPC + 1;
            end
          end else if (!Busy) begin
            m_open = 0; m_free = cyc + GAPC + 1;
          end
        end
      end else if (cyc >= m_free && !Busy && (|req_valid)) begin
        for (int s = 1; s <= NREQ; s++) begin
          int w;
          w = (m_ptr + s) % NREQ;
          if (!e_dv && req_valid[w]) begin
            e_dv = 1; e_rdy = 4'(1 << w); e_gid = 2'(w);
            e_pd = req_data[w*DW +: DW]; e_pe = req_par_en[w]; e_pt = req_par_typ[w];
            m_ptr = w; m_open = 1; m_iss = cyc; m_bseen = 0;
          end
        end
      end
      e_act = m_open || (cyc + 1 < m_free);
    end
    #1;
    if (m_on) begin
      chk("m_data_valid", 32'(DATA_VALID), 32'(e_dv));
      chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
      chk("m_grant_id", 32'(grant_id), 32'(e_gid));
      chk("m_p_data", 32'(P_DATA), 32'(e_pd));
      chk("m_par_en", 32'(PAR_EN), 32'(e_pe));
      chk("m_par_typ", 32'(PAR_TYP), 32'(e_pt));
      chk("m_active", 32'(active), 32'(e_act));
      chk("m_timeout_err", 32'(timeout_err), 32'(e_to));
    end
  end

  task automatic wait_dv(input int bound, input string nm);
    int i;
    for (i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (DATA_VALID === 1'b1) break;
    end
    if (i == bound) bound_fail(nm);
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int i;
    for (i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (active === 1'b0) break;
    end
    if (i == bound) bound_fail(nm);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int k;
    int i;
    rst = 1'b0; req_valid = '0; req_data = '0; req_par_en = '0; req_par_typ = '0;
    stub_en = 1'b1; ext_busy = 1'b0; auto_clr = 1'b1; bcnt = 0; Busy = 1'b0;
    prev_busy = 1'b0; last_fall = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", 32'(DATA_VALID), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_pdata", 32'(P_DATA), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single request from requester 2
    @(negedge clk);
    req_data = {8'h44, 8'hCC, 8'h22, 8'h11};
    req_par_en = 4'b0100; req_par_typ = 4'b0000;
    req_valid = 4'b0100;
    @(posedge clk); #1;
    chk("single_dv", 32'(DATA_VALID), 1);
    chk("single_pdata", 32'(P_DATA), 32'hCC);
    chk("single_ready", 32'(req_ready), 32'b0100);
    chk("single_gid", 32'(grant_id), 2);
    chk("single_paren", 32'(PAR_EN), 1);
    chk("single_partyp", 32'(PAR_TYP), 0);
    @(posedge clk); #1;
    chk("single_dv_pulse", 32'(DATA_VALID), 0);
    chk("single_hold", 32'(P_DATA), 32'hCC);
    wait_idle(60, "single_idle");

    // Fairness with all four requesters held valid
    do_reset(2);
    @(negedge clk);
    auto_clr = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_par_en = 4'b0110; req_par_typ = 4'b1010;
    req_valid = 4'hF;
    for (int f = 0; f < 8; f++) begin
      wait_dv(100, "fair_wait");
      chk("fair_order", 32'(grant_id), 32'(f % 4));
      chk("fair_one_ready", 32'($countones(req_ready)), 1);
      if (f > 0) chk("fair_gap", 32'(cyc - last_fall >= GAPC + 1), 1);
    end
    @(negedge clk);
    req_valid = '0; auto_clr = 1'b1;
    wait_idle(60, "fair_idle");

    // Timeout with a transmitter that never goes busy
    @(negedge clk);
    stub_en = 1'b0;
    req_valid = 4'b1010;
    wait_dv(10, "to_wait1");
    chk("to_gid1", 32'(grant_id), 1);
    k = 0;
    for (i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (timeout_err === 1'b1) break;
    end
    if (i > 20) bound_fail("to_pulse"); else chk("to_latency", 32'(i), 5);
    for (i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (DATA_VALID === 1'b1) break;
    end
    if (i > 20) bound_fail("to_next"); else chk("to_next_delay", 32'(i), 4);
    chk("to_gid2", 32'(grant_id), 3);
    wait_idle(40, "to_idle");

    // External busy holds off a grant
    @(negedge clk);
    stub_en = 1'b1; ext_busy = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("ext_no_grant", 32'(DATA_VALID), 0);
    end
    @(negedge clk);
    ext_busy = 1'b0;
    wait_dv(10, "ext_wait");
    chk("ext_gid", 32'(grant_id), 0);
    chk("ext_ready", 32'(req_ready), 32'b0001);
    wait_idle(60, "ext_idle");

    // Reset in the middle of a frame
    @(negedge clk);
    req_valid = 4'b0010;
    wait_dv(10, "rm_wait");
    chk("rm_gid", 32'(grant_id), 1);
    repeat (4) @(negedge clk);
    req_valid = req_valid | 4'b0101;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rm_dv", 32'(DATA_VALID), 0);
    chk("rm_ready", 32'(req_ready), 0);
    chk("rm_pdata", 32'(P_DATA), 0);
    chk("rm_paren", 32'(PAR_EN), 0);
    chk("rm_partyp", 32'(PAR_TYP), 0);
    chk("rm_gid0", 32'(grant_id), 0);
    chk("rm_active", 32'(active), 0);
    chk("rm_to", 32'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_dv(50, "rm_after1");
    chk("rm_first", 32'(grant_id), 0);
    wait_dv(60, "rm_after2");
    chk("rm_second", 32'(grant_id), 2);
    wait_idle(60, "rm_idle");

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
